// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite bus bundle between a master and the block-RAM controller.
// HREADY is the system ready, driven by the master side (interconnect).
interface ahb_bram_ctrl_if #(
    parameter int BITWIDTH = 32
);
    logic                HSEL;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [BITWIDTH-1:0] HWDATA;
    logic                HREADY;
    logic                HREADYOUT;
    logic                HRESP;
    logic [BITWIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave onto a word-addressed sync BRAM; sub-word writes merge into ram_dout (RMW). Optional AHB_BRAM_WRPROT_EN.
// Latency: zero-wait reads/writes (RAM read launched from the address phase); errors take the 2-cycle ERROR response.
// Backpressure: HREADYOUT drops only in the first ERROR cycle; back-to-back same-word traffic never stalls.
module ahb_bram_ctrl #(
    parameter int          MEMWIDTH   = 10,
    parameter int          BITWIDTH   = 32,
    parameter logic [31:0] WRPROT_TOP = 32'h100
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahb_bram_ctrl_if.slave      bus,
    output logic [MEMWIDTH-2:0] ram_awrite,
    output logic [MEMWIDTH-2:0] ram_aread,
    output logic                ram_we,
    output logic [BITWIDTH-1:0] ram_din,
    input  logic [BITWIDTH-1:0] ram_dout
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, ERR1, ERR2} state_t;

    state_t              state_q, state_d;
    logic [MEMWIDTH:0]   addr_q;
    logic [2:0]          size_q;
    logic                accept;
    logic                bad_xfer;
    logic                wr_prot;
    logic [4:0]          byte_bit;
    logic [4:0]          half_bit;
    logic [BITWIDTH-1:0] merged;
    logic                unused_bits;

    assign accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign ram_aread = bus.HADDR[MEMWIDTH:2];

    always_comb begin
        bad_xfer = 1'b0;
        case (bus.HSIZE)
            3'd0:    bad_xfer = 1'b0;
            3'd1:    bad_xfer = bus.HADDR[0];
            3'd2:    bad_xfer = |bus.HADDR[1:0];
            default: bad_xfer = 1'b1;
        endcase
    end

`ifdef AHB_BRAM_WRPROT_EN
    assign wr_prot = bus.HWRITE &
                     ({{(31-MEMWIDTH){1'b0}}, bus.HADDR[MEMWIDTH:0]} < WRPROT_TOP);
    assign unused_bits = ^{bus.HADDR[31:MEMWIDTH+1], bus.HTRANS[0]};
`else
    assign wr_prot     = 1'b0;
    assign unused_bits = ^{bus.HADDR[31:MEMWIDTH+1], bus.HTRANS[0], WRPROT_TOP};
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= bus.HADDR[MEMWIDTH:0];
                size_q <= bus.HSIZE;
            end
        end
    end

    // Little-endian lane merge: ram_dout already holds the addressed word
    // (write-first RAM), so only the addressed lanes are replaced.
    assign byte_bit = {addr_q[1:0], 3'b000};
    assign half_bit = {addr_q[1], 4'b0000};

    always_comb begin
        merged = ram_dout;
        case (size_q)
            3'd0:    merged[byte_bit +: 8]  = bus.HWDATA[byte_bit +: 8];
            3'd1:    merged[half_bit +: 16] = bus.HWDATA[half_bit +: 16];
            default: merged = bus.HWDATA;
        endcase
    end

    always_comb begin
        state_d       = IDLE;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
        ram_we        = 1'b0;
        ram_awrite    = '0;
        ram_din       = '0;

        if (accept) begin
            if (bad_xfer | wr_prot) state_d = ERR1;
            else if (bus.HWRITE)    state_d = WRITE;
            else                    state_d = READ;
        end

        case (state_q)
            READ:  bus.HRDATA = ram_dout;
            WRITE: begin
                ram_we     = 1'b1;
                ram_awrite = addr_q[MEMWIDTH:2];
                ram_din    = merged;
            end
            ERR1: begin
                state_d       = ERR2;
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            ERR2:    bus.HRESP = 1'b1;
            default: ;
        endcase

        // Reset overrides everything so a pending write is dropped this cycle.
        if (!HRESETn) begin
            state_d       = IDLE;
            bus.HREADYOUT = 1'b1;
            bus.HRESP     = 1'b0;
            bus.HRDATA    = '0;
            ram_we        = 1'b0;
            ram_awrite    = '0;
            ram_din       = '0;
        end
    end
endmodule
